// File: rtl/slib_filter_pkg.sv
// Shared types and helpers for the time-shared glitch filter bank.
package slib_filter_pkg;

  typedef enum logic [0:0] {FS_IDLE, FS_SWEEP} filt_state_t;

  // Bits needed to hold a count in 0..size
  function automatic int unsigned cnt_width(input int unsigned size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/slib_filter_update.sv
// Shared saturating up/down counter update for one filter channel (combinational).
// Optional SLIB_FILTER_MASK_EN adds an enable that forces the channel to zero.
module slib_filter_update
  import slib_filter_pkg::*;
#(
  parameter int unsigned SIZE = 4,
  parameter int unsigned CW   = cnt_width(SIZE)
) (
  input  logic [CW-1:0] cnt,
  input  logic          d,
  input  logic          q_old,
`ifdef SLIB_FILTER_MASK_EN
  input  logic          en,
`endif
  output logic [CW-1:0] cnt_next,
  output logic          q_next
);

  always_comb begin
    cnt_next = cnt;
    q_next   = q_old;
    if (d && (cnt != CW'(SIZE))) begin
      cnt_next = cnt + CW'(1);
    end else if (!d && (cnt != '0)) begin
      cnt_next = cnt - CW'(1);
    end
    // Output only switches at the rails; in between it holds (hysteresis)
    if (cnt_next == CW'(SIZE)) begin
      q_next = 1'b1;
    end else if (cnt_next == '0) begin
      q_next = 1'b0;
    end
`ifdef SLIB_FILTER_MASK_EN
    if (!en) begin
      cnt_next = '0;
      q_next   = 1'b0;
    end
`endif
  end

endmodule

// File: rtl/slib_filter_scheduler.sv
// Round-robin scheduler sharing one filter update unit across NUM_CH modem/status lines.
// Optional SLIB_FILTER_MASK_EN adds the per-channel EN port.
module slib_filter_scheduler
  import slib_filter_pkg::*;
#(
  parameter int unsigned NUM_CH = 5,
  parameter int unsigned SIZE   = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CE,
  input  logic [NUM_CH-1:0] D,
  output logic [NUM_CH-1:0] Q,
  output logic              BUSY,
  output logic              DONE,
  output logic              OVR
`ifdef SLIB_FILTER_MASK_EN
  ,
  input  logic [NUM_CH-1:0] EN
`endif
);

  localparam int unsigned CW = cnt_width(SIZE);
  localparam int unsigned PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PW-1:0] LAST = PW'(NUM_CH - 1);

  filt_state_t       state, state_d;
  logic [PW-1:0]     ptr, ptr_d;
  logic              pending, pending_d;
  logic              ovr_d, done_d, snap_ld, upd;
  logic [NUM_CH-1:0] dsnap;
  logic [CW-1:0]     cnt_q [NUM_CH];
  logic [CW-1:0]     cnt_next;
  logic              q_next;

  slib_filter_update #(.SIZE(SIZE), .CW(CW)) u_update (
    .cnt      (cnt_q[ptr]),
    .d        (dsnap[ptr]),
    .q_old    (Q[ptr]),
`ifdef SLIB_FILTER_MASK_EN
    .en       (EN[ptr]),
`endif
    .cnt_next (cnt_next),
    .q_next   (q_next)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= FS_IDLE;
    else        state <= state_d;
  end

  // Next-state: one channel per clock, restart straight out of the last slot if a tick is queued
  always_comb begin
    state_d   = state;
    ptr_d     = ptr;
    pending_d = pending;
    ovr_d     = OVR;
    done_d    = 1'b0;
    snap_ld   = 1'b0;
    upd       = 1'b0;
    case (state)
      FS_IDLE: begin
        if (CE) begin
          state_d = FS_SWEEP;
          ptr_d   = '0;
          snap_ld = 1'b1;
        end
      end
      FS_SWEEP: begin
        upd = 1'b1;
        if (ptr == LAST) begin
          done_d = 1'b1;
          ptr_d  = '0;
          if (pending || CE) begin
            snap_ld   = 1'b1;
            pending_d = 1'b0;
            ovr_d     = OVR | (pending & CE);
          end else begin
            state_d = FS_IDLE;
          end
        end else begin
          ptr_d = ptr + PW'(1);
          if (CE) begin
            if (pending) ovr_d = 1'b1;
            else         pending_d = 1'b1;
          end
        end
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr     <= '0;
      pending <= 1'b0;
      OVR     <= 1'b0;
      DONE    <= 1'b0;
      BUSY    <= 1'b0;
      dsnap   <= '0;
      Q       <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) cnt_q[i] <= '0;
    end else begin
      ptr     <= ptr_d;
      pending <= pending_d;
      OVR     <= ovr_d;
      DONE    <= done_d;
      BUSY    <= (state_d == FS_SWEEP);
      if (snap_ld) dsnap <= D;
      if (upd) begin
        cnt_q[ptr] <= cnt_next;
        Q[ptr]     <= q_next;
      end
    end
  end

endmodule

// File: tb/tb_slib_filter_scheduler.sv
// Directed self-checking bench for slib_filter_scheduler (NUM_CH=5, SIZE=4).
module tb_slib_filter_scheduler;

  logic       CLK;
  logic       RST_N;
  logic       CE;
  logic [4:0] D;
  logic [4:0] Q;
  logic       BUSY;
  logic       DONE;
  logic       OVR;
`ifdef SLIB_FILTER_MASK_EN
  logic [4:0] EN;
`endif

  int total;
  int bad;
  int done_cnt;

  slib_filter_scheduler #(.NUM_CH(5), .SIZE(4)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .CE    (CE),
    .D     (D),
    .Q     (Q),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .OVR   (OVR)
`ifdef SLIB_FILTER_MASK_EN
    ,
    .EN    (EN)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic do_reset;
    CE    = 1'b0;
    D     = '0;
    RST_N = 1'b0;
    step(2);
    RST_N = 1'b1;
    step(1);
  endtask

  // Returns 1ns after the edge that sampled CE
  task automatic ce_pulse;
    CE = 1'b1;
    step(1);
    CE = 1'b0;
  endtask

  // One sample tick, then idle until 8 clocks have passed; counts DONE pulses
  task automatic sweep_tick(input logic [4:0] dval);
    D = dval;
    ce_pulse();
    repeat (7) begin
      step(1);
      if (DONE === 1'b1) done_cnt++;
    end
  endtask

  task automatic test_reset;
    CE    = 1'b0;
    D     = '1;
    RST_N = 1'b0;
    #7;
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL reset_q got=%b exp=%b", Q, 5'b00000); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
    total++; if (OVR !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%b exp=0", OVR); end
    step(2);
    RST_N = 1'b1;
    D     = '0;
    step(1);
  endtask

  task automatic test_rise;
    do_reset();
    done_cnt = 0;
    for (int i = 0; i < 3; i++) sweep_tick(5'b11111);
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL rise_early got=%b exp=%b", Q, 5'b00000); end
    sweep_tick(5'b11111);
    total++; if (Q !== 5'b11111) begin bad++; $display("FAIL rise_q got=%b exp=%b", Q, 5'b11111); end
    total++; if (done_cnt != 4) begin bad++; $display("FAIL rise_done_count got=%0d exp=4", done_cnt); end
  endtask

  task automatic test_glitch;
    logic glitch;
    do_reset();
    glitch = 1'b0;
    for (int i = 0; i < 6; i++) begin
      D = (i < 3) ? 5'b00001 : 5'b00000;
      ce_pulse();
      if (Q !== 5'b00000) glitch = 1'b1;
      repeat (7) begin
        step(1);
        if (Q !== 5'b00000) glitch = 1'b1;
      end
    end
    total++; if (glitch !== 1'b0) begin bad++; $display("FAIL glitch_q0 got=%b exp=0", glitch); end
    // Count must be back at 0: four more highs are needed to switch
    for (int i = 0; i < 3; i++) sweep_tick(5'b00001);
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL glitch_count_zero got=%b exp=%b", Q, 5'b00000); end
    sweep_tick(5'b00001);
    total++; if (Q !== 5'b00001) begin bad++; $display("FAIL glitch_rise got=%b exp=%b", Q, 5'b00001); end
  endtask

  task automatic test_latency;
    logic [4:0] exp_q;
    do_reset();
    for (int i = 0; i < 3; i++) sweep_tick(5'b11111);
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL lat_busy_pre got=%b exp=0", BUSY); end
    ce_pulse();
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL lat_busy_t got=%b exp=1", BUSY); end
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL lat_q_t got=%b exp=%b", Q, 5'b00000); end
    for (int j = 1; j <= 5; j++) begin
      step(1);
      exp_q = 5'((1 << j) - 1);
      total++; if (Q !== exp_q) begin bad++; $display("FAIL lat_q_edge%0d got=%b exp=%b", j, Q, exp_q); end
      if (j < 5) begin
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL lat_busy_edge%0d got=%b exp=1", j, BUSY); end
      end
    end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL lat_busy_end got=%b exp=0", BUSY); end
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL lat_done got=%b exp=1", DONE); end
    step(1);
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL lat_done_pulse got=%b exp=0", DONE); end
  endtask

  task automatic test_back_to_back;
    do_reset();
    D = 5'b00000;
    ce_pulse();
    step(1);
    CE = 1'b1;
    step(1);
    total++; if (OVR !== 1'b0) begin bad++; $display("FAIL b2b_ovr_first got=%b exp=0", OVR); end
    step(1);
    CE = 1'b0;
    total++; if (OVR !== 1'b1) begin bad++; $display("FAIL b2b_ovr_second got=%b exp=1", OVR); end
    step(2);
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL b2b_done1 got=%b exp=1", DONE); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL b2b_busy_restart got=%b exp=1", BUSY); end
    step(5);
    total++; if (DONE !== 1'b1) begin bad++; $display("FAIL b2b_done2 got=%b exp=1", DONE); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL b2b_busy_end got=%b exp=0", BUSY); end
    step(1);
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL b2b_no_third got=%b exp=0", DONE); end
    step(20);
    total++; if (OVR !== 1'b1) begin bad++; $display("FAIL b2b_ovr_sticky got=%b exp=1", OVR); end
  endtask

  task automatic test_saturate;
    do_reset();
    for (int i = 0; i < 10; i++) sweep_tick(5'b11111);
    total++; if (Q !== 5'b11111) begin bad++; $display("FAIL sat_high got=%b exp=%b", Q, 5'b11111); end
    for (int i = 0; i < 3; i++) sweep_tick(5'b00000);
    total++; if (Q !== 5'b11111) begin bad++; $display("FAIL sat_hold got=%b exp=%b", Q, 5'b11111); end
    sweep_tick(5'b00000);
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL sat_fall got=%b exp=%b", Q, 5'b00000); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 4; i++) sweep_tick(5'b11111);
    D = 5'b00000;
    ce_pulse();
    step(2);
    #2;
    RST_N = 1'b0;
    #1;
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL mid_reset_q got=%b exp=%b", Q, 5'b00000); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mid_reset_busy got=%b exp=0", BUSY); end
    total++; if (OVR !== 1'b0) begin bad++; $display("FAIL mid_reset_ovr got=%b exp=0", OVR); end
    step(2);
    RST_N = 1'b1;
    step(1);
    // Counts were cleared: one high sample must not switch anything
    sweep_tick(5'b11111);
    total++; if (Q !== 5'b00000) begin bad++; $display("FAIL mid_reset_cnt got=%b exp=%b", Q, 5'b00000); end
`ifdef SLIB_FILTER_MASK_EN
    do_reset();
    EN = 5'b11011;
    for (int i = 0; i < 4; i++) sweep_tick(5'b11111);
    total++; if (Q !== 5'b11011) begin bad++; $display("FAIL mask_q got=%b exp=%b", Q, 5'b11011); end
    EN = 5'b11111;
`endif
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    done_cnt = 0;
    CE       = 1'b0;
    D        = '0;
    RST_N    = 1'b1;
`ifdef SLIB_FILTER_MASK_EN
    EN       = 5'b11111;
`endif
    test_reset();
    test_rise();
    test_glitch();
    test_latency();
    test_back_to_back();
    test_saturate();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
